// File: rtl/ks_wide_add_seq_if.sv
// ks_wide_add_seq_if
// Handshake and data bundle for the wide add/subtract sequencer.
//   master : the requester. Drives in_valid, op_sub, a and b, and out_ready to
//            accept a result.
//   slave  : the sequencer. Drives in_ready, out_valid, result, carry_out,
//            overflow and busy.
// Operand and result width is W = N*SLICES.
interface ks_wide_add_seq_if #(
  parameter int N      = 8,
  parameter int SLICES = 4
);
  localparam int W = N * SLICES;

  logic         in_valid;
  logic         in_ready;
  logic         op_sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;
  logic         busy;

  modport master (
    output in_valid, op_sub, a, b, out_ready,
    input  in_ready, out_valid, result, carry_out, overflow, busy
  );

  modport slave (
    input  in_valid, op_sub, a, b, out_ready,
    output in_ready, out_valid, result, carry_out, overflow, busy
  );
endinterface

// File: rtl/ks_wide_add_seq.sv
// ks_wide_add_seq
// Multi-cycle W-bit add/subtract (W = N*SLICES). A single N-bit Kogge-Stone
// adder is reused once per slice, LSB slice first, and the carry between
// slices is held in a register. Only one operation is in flight at a time.
// Ports:
//   CLOCK_50 : system clock, rising edge
//   reset    : asynchronous, active-high
//   bus      : ks_wide_add_seq_if.slave
//              in_valid/in_ready   : operand handshake (in_ready only in IDLE)
//              op_sub, a, b        : operation and operands, sampled on accept
//              out_valid/out_ready : result handshake
//              result, carry_out, overflow : registered, held until the next
//                                    operation completes
//              busy                : high in RUN or DONE

// N-bit parallel-prefix adder. The carry-in is folded in as an extra
// generate bit below bit 0, so the prefix tree produces every carry,
// including carry-out, in one pass.
module kogge_stone_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);
  localparam int M      = N + 1;
  localparam int STAGES = $clog2(M);

  logic [M-1:0] g0;
  logic [M-1:0] p0;
  logic [M-1:0] carries;  // carries[i] is the carry into bit i; carries[N] is cout

  assign g0 = {a & b, cin};
  assign p0 = {a ^ b, 1'b0};

  always_comb begin
    logic [M-1:0] gg, pp, gn, pn;
    gg = g0;
    pp = p0;
    gn = g0;
    pn = p0;
    for (int s = 0; s < STAGES; s++) begin
      gn = gg;
      pn = pp;
      for (int i = 0; i < M; i++) begin
        if (i >= (1 << s)) begin
          gn[i] = gg[i] | (pp[i] & gg[i - (1 << s)]);
          pn[i] = pp[i] & pp[i - (1 << s)];
        end
      end
      gg = gn;
      pp = pn;
    end
    carries = gg;
  end

  assign sum  = p0[M-1:1] ^ carries[N-1:0];
  assign cout = carries[N];
endmodule

module ks_wide_add_seq #(
  parameter int N      = 8,
  parameter int SLICES = 4
) (
  input  logic            CLOCK_50,
  input  logic            reset,
  ks_wide_add_seq_if.slave bus
);
  localparam int W  = N * SLICES;
  localparam int CW = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [CW-1:0] LAST = CW'(SLICES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_sh, b_sh, res_sh, res_next;
  logic [W-1:0]  result_q;
  logic          carry_reg, carry_q, ovf_q;
  logic          sign_a, sign_b;
  logic [CW-1:0] cnt;

  logic [N-1:0]  slice_sum;
  logic          slice_cout;

  kogge_stone_adder #(.N(N)) u_adder (
    .a    (a_sh[N-1:0]),
    .b    (b_sh[N-1:0]),
    .cin  (carry_reg),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Each slice sum enters at the top and the register shifts right, so after
  // SLICES steps the LSB slice has reached bits [N-1:0].
  generate
    if (SLICES == 1) begin : g_one_slice
      assign res_next = slice_sum;
    end else begin : g_multi_slice
      assign res_next = {slice_sum, res_sh[W-1:N]};
    end
  endgenerate

  // State register
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and handshake outputs. Outputs depend on state only, so
  // in_valid/out_ready never reach an output combinationally.
  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that skips
    // an assignment would otherwise infer a latch.
    state_d      = state_q;
    bus.in_ready = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy     = 1'b1;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b0;
        if (bus.in_valid) state_d = RUN;
      end
      RUN: begin
        if (cnt == LAST) state_d = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath. The operand and partial-result shift registers are plain
  // flops, so they are cleared with everything else; an aborted operation
  // leaves nothing behind.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      a_sh      <= '0;
      b_sh      <= '0;
      res_sh    <= '0;
      result_q  <= '0;
      carry_reg <= 1'b0;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            // Subtract is a + ~b + 1: invert b here, the +1 rides in as the
            // first slice carry-in.
            a_sh      <= bus.a;
            b_sh      <= bus.op_sub ? ~bus.b : bus.b;
            carry_reg <= bus.op_sub;
            cnt       <= '0;
            sign_a    <= bus.a[W-1];
            sign_b    <= bus.op_sub ? ~bus.b[W-1] : bus.b[W-1];
          end
        end
        RUN: begin
          a_sh      <= a_sh >> N;
          b_sh      <= b_sh >> N;
          res_sh    <= res_next;
          carry_reg <= slice_cout;
          cnt       <= cnt + CW'(1);
          if (cnt == LAST) begin
            result_q <= res_next;
            carry_q  <= slice_cout;
            // Signed overflow: both effective operands share a sign that
            // differs from the sign of the sum.
            ovf_q    <= (sign_a == sign_b) && (slice_sum[N-1] != sign_a);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.result    = result_q;
  assign bus.carry_out = carry_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: doc/ks_wide_add_seq.md
Name: ks_wide_add_seq

Overview:
Multi-cycle wide add/subtract sequencer that reuses one N-bit kogge_stone_adder instance over SLICES slices, LSB slice first, chaining the carry through a register. It is the serial front end the FPU mantissa path uses when operands are wider than the prefix adder built in hardware. A valid/ready handshake is used on both the input and the output side. Only one operation is in flight at a time.

Parameters:
N, 8, slice width; the width of the instantiated kogge_stone_adder.
SLICES, 4, number of slices; operand width W = N*SLICES. Legal range is SLICES >= 1.

Ports:
CLOCK_50  in  1  single system clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-high reset.
in_valid  in  1  operand request.
in_ready  out  1  block can accept an operand; high only in IDLE.
op_sub  in  1  0 = a+b, 1 = a-b; sampled on accept.
a  in  W  operand A, unsigned/two's complement.
b  in  W  operand B.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts the result.
result  out  W  sum or difference modulo 2^W.
carry_out  out  1  carry out of bit W-1; for subtract, 1 means no borrow.
overflow  out  1  two's-complement signed overflow.
busy  out  1  high in RUN or DONE.

Behaviour:
- States: IDLE, RUN, DONE. Reset enters IDLE.
- Reset values: in_ready=1; out_valid=0; busy=0; result=0; carry_out=0; overflow=0. The slice counter, carry register and operand shift registers are all cleared.
- Reset is asynchronous and applies immediately in any state, including mid-RUN. The in-flight operation is discarded with no partial output.
- IDLE:
  - The block accepts when in_valid && in_ready at a clock edge.
  - On accept it latches a_sh=a and b_sh=(op_sub ? ~b : b), sets carry_reg=op_sub and cnt=0, and records sign_a=a[W-1] and sign_b=b_sh[W-1].
  - It then enters RUN.
- RUN, one slice per cycle:
  - Adder inputs are A=a_sh[N-1:0], B=b_sh[N-1:0], Cin=carry_reg.
  - At each edge: a_sh>>=N and b_sh>>=N; the result shift register takes the adder Sum into bits [W-1:W-N] and shifts right by N; carry_reg=Cout; cnt+=1.
  - When cnt==SLICES-1 at the edge, the block enters DONE. Also at that edge: carry_out=Cout, and overflow=(sign_a==sign_b) && (Sum[N-1]!=sign_a).
- DONE:
  - out_valid=1. result, carry_out and overflow are held stable while out_ready=0.
  - in_ready=0, and in_valid is ignored.
  - On out_valid && out_ready at an edge, the block enters IDLE. out_valid drops after that edge.
- Latency: with accept at edge k, out_valid is high after edge k+SLICES. A new accept is possible at the first edge after the result handshake. Throughput is at most one op per SLICES+2 cycles.
- result, carry_out and overflow are registered. They change only on the DONE entry edge and on reset, and they keep their last value while in IDLE.
- SLICES=1: RUN lasts exactly one cycle. cnt is at least 1 bit wide.
- The adder path is purely combinational from registers. There is no combinational path from in_valid or out_ready to any output other than through state.

Test Plan:
1. N=8, SLICES=4: add a=0x000000FF, b=0x00000001 -> result=0x00000100, carry_out=0, overflow=0; out_valid rises exactly 4 edges after accept.
2. Add a=0xFFFFFFFF, b=0x00000001 (carry ripples through all slices) -> result=0x00000000, carry_out=1, overflow=0.
3. Add a=0x7FFFFFFF, b=0x00000001 -> result=0x80000000, overflow=1, carry_out=0. Sub a=0x80000000, b=0x00000001 -> result=0x7FFFFFFF, overflow=1, carry_out=1.
4. Sub a=5, b=7 -> result=0xFFFFFFFE, carry_out=0 (borrow), overflow=0. Sub a=7, b=7 -> result=0, carry_out=1.
5. Backpressure: hold out_ready=0 for 3 cycles after out_valid while driving in_valid=1 with new operands -> result unchanged, in_ready=0, and no accept occurs. Then raise out_ready -> IDLE, and the pending operation is accepted on the next edge and produces the correct result.
6. Assert reset 2 cycles into RUN -> all outputs go to reset values immediately and in_ready=1 after release. A following add 0x12345678+0x11111111 -> 0x23456789, with no leftover carry.
